// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU op codes, forward selects, result-source encodings
// and the default datapath widths.
package riscv_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/execute_stage_if.sv
// E-stage bundle in, branch redirect and M-stage bundle out.
// The master side is whoever drives the ID/EX register and hazard controls.
interface execute_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) ();

    logic              RegWriteE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic              ALUSrcE;
    logic [1:0]        ResultSrcE;
    logic [2:0]        ALUControlE;
    logic [REG_AW-1:0] RdE;
    logic [XLEN-1:0]   RD1_E;
    logic [XLEN-1:0]   RD2_E;
    logic [XLEN-1:0]   ImmExtE;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [XLEN-1:0]   ResultW;
    logic              StallM;
    logic              FlushM;

    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic [1:0]        ResultSrcM;
    logic [REG_AW-1:0] RdM;
    logic [XLEN-1:0]   ALUResultM;
    logic [XLEN-1:0]   WriteDataM;
    logic [XLEN-1:0]   PCPlus4M;

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ForwardAE, ForwardBE,
               ResultW, StallM, FlushM,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM,
               ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ForwardAE, ForwardBE,
               ResultW, StallM, FlushM,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM,
               ALUResultM, WriteDataM, PCPlus4M
    );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub/and/or/signed slt, wrapping arithmetic.
// Unassigned op codes produce zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic                   w_lt;

    assign w_a_s = SrcA;
    assign w_b_s = SrcB;
    assign w_lt  = (w_a_s < w_b_s);

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, w_lt};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding muxes, ALU, beq/jump redirect and the EX/MEM
// pipeline register with flush-over-stall priority.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  bus
);

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_write_data;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_zero;

    logic              r_reg_write;
    logic              r_mem_write;
    logic [1:0]        r_result_src;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_write_data;
    logic [XLEN-1:0]   r_pc_plus4;

    // Select 11 falls back to the register-file value.
    function automatic logic [XLEN-1:0] fwd(input logic [1:0]      sel,
                                            input logic [XLEN-1:0] rf,
                                            input logic [XLEN-1:0] wb,
                                            input logic [XLEN-1:0] mem);
        case (sel)
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rf;
        endcase
    endfunction

    // The M-stage forward taps the registered result so dependent ops need no stall.
    assign w_src_a      = fwd(bus.ForwardAE, bus.RD1_E, bus.ResultW, r_alu_result);
    assign w_write_data = fwd(bus.ForwardBE, bus.RD2_E, bus.ResultW, r_alu_result);
    assign w_src_b      = bus.ALUSrcE ? bus.ImmExtE : w_write_data;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (bus.ALUControlE),
        .ALUResult  (w_alu_result),
        .Zero       (w_zero)
    );

    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
    assign bus.PCSrcE    = (bus.BranchE & w_zero) | bus.JumpE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
            r_rd         <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else if (bus.FlushM) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
            r_rd         <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else if (!bus.StallM) begin
            r_reg_write  <= bus.RegWriteE;
            r_mem_write  <= bus.MemWriteE;
            r_result_src <= bus.ResultSrcE;
            r_rd         <= bus.RdE;
            r_alu_result <= w_alu_result;
            r_write_data <= w_write_data;
            r_pc_plus4   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM  = r_reg_write;
    assign bus.MemWriteM  = r_mem_write;
    assign bus.ResultSrcM = r_result_src;
    assign bus.RdM        = r_rd;
    assign bus.ALUResultM = r_alu_result;
    assign bus.WriteDataM = r_write_data;
    assign bus.PCPlus4M   = r_pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_execute_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    logic chk_en;
    int   checks;
    int   errors;

    execute_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    execute_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } mstate_t;

    mstate_t m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return bus.ResultW;
        if (sel == 2'd2) return m.alu;
        return rf;
    endfunction

    function automatic logic [31:0] m_wd();
        return m_fwd(bus.ForwardBE, bus.RD2_E);
    endfunction

    function automatic logic [31:0] m_res();
        logic [31:0] b;
        b = bus.ALUSrcE ? bus.ImmExtE : m_wd();
        return m_alu(bus.ALUControlE, m_fwd(bus.ForwardAE, bus.RD1_E), b);
    endfunction

    // Expected EX/MEM contents
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '0;
        end else if (bus.FlushM) begin
            m <= '0;
        end else if (!bus.StallM) begin
            m <= '{rw: bus.RegWriteE, mw: bus.MemWriteE, rs: bus.ResultSrcE, rd: bus.RdE,
                   alu: m_res(), wd: m_wd(), pc4: bus.PCPlus4E};
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("PCSrcE", {31'd0, bus.PCSrcE},
                {31'd0, (bus.BranchE && (m_res() == 32'd0)) || bus.JumpE});
            chk("PCTargetE", bus.PCTargetE, bus.PCE + bus.ImmExtE);
            chk("RegWriteM", {31'd0, bus.RegWriteM}, {31'd0, m.rw});
            chk("MemWriteM", {31'd0, bus.MemWriteM}, {31'd0, m.mw});
            chk("ResultSrcM", {30'd0, bus.ResultSrcM}, {30'd0, m.rs});
            chk("RdM", {27'd0, bus.RdM}, {27'd0, m.rd});
            chk("ALUResultM", bus.ALUResultM, m.alu);
            chk("WriteDataM", bus.WriteDataM, m.wd);
            chk("PCPlus4M", bus.PCPlus4M, m.pc4);
        end
    end

    task automatic clear_e();
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.BranchE = 0;
        bus.ALUSrcE = 0; bus.ResultSrcE = 0; bus.ALUControlE = ALU_ADD; bus.RdE = 0;
        bus.RD1_E = 0; bus.RD2_E = 0; bus.ImmExtE = 0; bus.PCE = 0; bus.PCPlus4E = 0;
        bus.ForwardAE = FWD_RF; bus.ForwardBE = FWD_RF; bus.ResultW = 0;
        bus.StallM = 0; bus.FlushM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, "_RegWriteM"}, {31'd0, bus.RegWriteM}, 32'd0);
        chk({tag, "_MemWriteM"}, {31'd0, bus.MemWriteM}, 32'd0);
        chk({tag, "_RdM"}, {27'd0, bus.RdM}, 32'd0);
        chk({tag, "_ALUResultM"}, bus.ALUResultM, 32'd0);
        chk({tag, "_WriteDataM"}, bus.WriteDataM, 32'd0);
        chk({tag, "_PCPlus4M"}, bus.PCPlus4M, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 0;
        rst = 1;
        clear_e();
        #1 rst = 0;
        #1 chk_m_zero("reset");
        repeat (2) tick();
        rst = 1;
        chk_en = 1;

        // add capture
        bus.RD1_E = 5; bus.RD2_E = 7; bus.RegWriteE = 1; bus.RdE = 3;
        bus.ResultSrcE = RES_PC4;
        tick();
        chk("add_ALUResultM", bus.ALUResultM, 32'd12);
        chk("add_RdM", {27'd0, bus.RdM}, 32'd3);
        chk("add_ResultSrcM", {30'd0, bus.ResultSrcM}, {30'd0, RES_PC4});

        // forwarding
        clear_e();
        bus.RD1_E = 32'h10;
        tick();
        bus.ResultW = 32'h20; bus.RD1_E = 1; bus.RD2_E = 2; bus.ALUControlE = ALU_SUB;
        bus.ForwardAE = FWD_MEM; bus.ForwardBE = FWD_WB;
        tick();
        chk("fwd_ALUResultM", bus.ALUResultM, 32'hFFFF_FFF0);
        chk("fwd_WriteDataM", bus.WriteDataM, 32'h20);
        bus.ForwardAE = 2'b11; bus.ForwardBE = FWD_RF;
        tick();
        chk("fwd11_ALUResultM", bus.ALUResultM, 32'hFFFF_FFFF);

        // signed slt and wrapping add
        clear_e();
        bus.ALUControlE = ALU_SLT; bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 1;
        tick();
        chk("slt_neg", bus.ALUResultM, 32'd1);
        bus.RD1_E = 1; bus.RD2_E = 32'hFFFF_FFFF;
        tick();
        chk("slt_pos", bus.ALUResultM, 32'd0);
        bus.ALUControlE = ALU_ADD; bus.BranchE = 1;
        #1 chk("add_wrap_zero", {31'd0, bus.PCSrcE}, 32'd1);
        tick();
        chk("add_wrap", bus.ALUResultM, 32'd0);

        // branch / jump
        clear_e();
        bus.BranchE = 1; bus.RD1_E = 9; bus.RD2_E = 9; bus.ALUControlE = ALU_SUB;
        bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
        #1 chk("beq_taken", {31'd0, bus.PCSrcE}, 32'd1);
        chk("beq_target", bus.PCTargetE, 32'hF8);
        bus.RD2_E = 8;
        #1 chk("beq_not_taken", {31'd0, bus.PCSrcE}, 32'd0);
        bus.JumpE = 1;
        #1 chk("jump", {31'd0, bus.PCSrcE}, 32'd1);
        tick();

        // stall, flush, flush over stall
        clear_e();
        bus.RD1_E = 32'h55; bus.RegWriteE = 1; bus.RdE = 7; bus.PCPlus4E = 32'h44;
        tick();
        bus.StallM = 1;
        for (int i = 0; i < 3; i++) begin
            bus.RD1_E = $urandom; bus.RdE = 5'($urandom); bus.RegWriteE = 0;
            bus.PCPlus4E = $urandom;
            tick();
            chk("stall_ALUResultM", bus.ALUResultM, 32'h55);
            chk("stall_RdM", {27'd0, bus.RdM}, 32'd7);
            chk("stall_PCPlus4M", bus.PCPlus4M, 32'h44);
        end
        bus.StallM = 0; bus.FlushM = 1; bus.MemWriteE = 1; bus.RegWriteE = 1;
        tick();
        chk_m_zero("flush");
        bus.FlushM = 0; bus.RD1_E = 32'h77;
        tick();
        bus.StallM = 1; bus.FlushM = 1;
        tick();
        chk_m_zero("flush_over_stall");

        // immediate operand and store data
        clear_e();
        bus.ALUSrcE = 1; bus.RD1_E = 32'h1000; bus.ImmExtE = 32'h10; bus.RD2_E = 32'hABCD;
        bus.MemWriteE = 1; bus.PCPlus4E = 32'h204;
        tick();
        chk("imm_ALUResultM", bus.ALUResultM, 32'h1010);
        chk("imm_WriteDataM", bus.WriteDataM, 32'hABCD);
        chk("imm_MemWriteM", {31'd0, bus.MemWriteM}, 32'd1);
        chk("imm_PCPlus4M", bus.PCPlus4M, 32'h204);

        // asynchronous reset mid-run
        #2 rst = 0;
        #1 chk_m_zero("async_rst");
        tick();
        chk_m_zero("rst_held");
        clear_e();
        rst = 1;
        bus.RD1_E = 5; bus.RD2_E = 7;
        tick();
        chk("post_rst_add", bus.ALUResultM, 32'd12);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.RegWriteE = 1'($urandom); bus.MemWriteE = 1'($urandom);
            bus.JumpE = ($urandom_range(0, 7) == 0); bus.BranchE = 1'($urandom);
            bus.ALUSrcE = 1'($urandom); bus.ResultSrcE = 2'($urandom);
            bus.ALUControlE = 3'($urandom); bus.RdE = 5'($urandom);
            bus.RD1_E = $urandom; bus.ImmExtE = $urandom;
            bus.RD2_E = ($urandom_range(0, 3) == 0) ? bus.RD1_E : $urandom;
            bus.PCE = $urandom; bus.PCPlus4E = $urandom; bus.ResultW = $urandom;
            bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
            bus.StallM = ($urandom_range(0, 7) == 0);
            bus.FlushM = ($urandom_range(0, 9) == 0);
            tick();
        end

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
